// File: rtl/my_addsub_seq_if.sv
// Start/busy/done handshake and operand/result bus of the sequential add/subtract unit.
// The master issues operations; the slave is the arithmetic unit.
interface my_addsub_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic             cin;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output start, op, cin, A, B,
        input  busy, done, result, c_out, ovf, zero, neg
    );

    modport slave (
        input  start, op, cin, A, B,
        output busy, done, result, c_out, ovf, zero, neg
    );
endinterface

// File: rtl/my_addsub_seq.sv
// Multi-cycle ADD/SUB/ADC/SBC unit: one CHUNK-bit slice per clock, LSB slice first,
// with a registered carry between slices and flags captured on the completion edge.
module my_addsub_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    my_addsub_seq_if.slave   bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        IDLE,
        RUN
    } stateType;

    stateType         state;
    stateType         nextState;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] resultReg;
    logic [WIDTH-1:0] nextResult;
    logic [CHUNK:0]   sliceSum;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             launch;
    logic             isLast;
    logic             busyReg;
    logic             doneReg;
    logic             cOutReg;
    logic             ovfReg;
    logic             zeroReg;
    logic             negReg;

    assign launch = (state == IDLE) && bus.start;
    assign isLast = (idx == LAST_IDX);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.start) nextState = RUN;
            RUN:     if (isLast)    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        sliceSum   = {1'b0, opA[idx*CHUNK +: CHUNK]} + {1'b0, opB[idx*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry};
        nextResult = resultReg;
        nextResult[idx*CHUNK +: CHUNK] = sliceSum[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opA       <= '0;
            opB       <= '0;
            resultReg <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
            cOutReg   <= 1'b0;
            ovfReg    <= 1'b0;
            zeroReg   <= 1'b0;
            negReg    <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            if (launch) begin
                // Subtraction is A + ~B + 1; the +1 (or the external carry) enters via the slice carry.
                opA     <= bus.A;
                opB     <= bus.op[0] ? ~bus.B : bus.B;
                case (bus.op)
                    2'b00:   carry <= 1'b0;
                    2'b01:   carry <= 1'b1;
                    default: carry <= bus.cin;
                endcase
                idx     <= '0;
                busyReg <= 1'b1;
            end else if (state == RUN) begin
                resultReg <= nextResult;
                carry     <= sliceSum[CHUNK];
                idx       <= isLast ? '0 : idx + 1'b1;
                if (isLast) begin
                    busyReg <= 1'b0;
                    doneReg <= 1'b1;
                    cOutReg <= sliceSum[CHUNK];
                    ovfReg  <= (opA[WIDTH-1] == opB[WIDTH-1]) && (nextResult[WIDTH-1] != opA[WIDTH-1]);
                    zeroReg <= (nextResult == '0);
                    negReg  <= nextResult[WIDTH-1];
                end
            end
        end
    end

    assign bus.busy   = busyReg;
    assign bus.done   = doneReg;
    assign bus.result = resultReg;
    assign bus.c_out  = cOutReg;
    assign bus.ovf    = ovfReg;
    assign bus.zero   = zeroReg;
    assign bus.neg    = negReg;
endmodule

// File: tb/tb_my_addsub_seq.sv
// Directed and randomised checks of my_addsub_seq for CHUNK = 1, 8 and 32 at WIDTH = 32.
// Flags are compared packed as {c_out, ovf, zero, neg}.
module tb_my_addsub_seq;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passCount = 0;
    int   failCount = 0;

    always #5 clk = ~clk;

    my_addsub_seq_if #(.WIDTH(32)) bus1 ();
    my_addsub_seq_if #(.WIDTH(32)) bus8 ();
    my_addsub_seq_if #(.WIDTH(32)) bus32 ();

    my_addsub_seq #(.WIDTH(32), .CHUNK(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    my_addsub_seq #(.WIDTH(32), .CHUNK(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    my_addsub_seq #(.WIDTH(32), .CHUNK(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // which: 0 -> CHUNK=1, 1 -> CHUNK=8, 2 -> CHUNK=32
    task automatic drive(input int which, input logic st, input logic [1:0] op, input logic cin,
                         input logic [31:0] a, input logic [31:0] b);
        case (which)
            0:       begin bus1.start = st;  bus1.op = op;  bus1.cin = cin;  bus1.A = a;  bus1.B = b;  end
            1:       begin bus8.start = st;  bus8.op = op;  bus8.cin = cin;  bus8.A = a;  bus8.B = b;  end
            default: begin bus32.start = st; bus32.op = op; bus32.cin = cin; bus32.A = a; bus32.B = b; end
        endcase
    endtask

    task automatic sample(input int which, output logic bsy, output logic dn,
                          output logic [31:0] res, output logic [3:0] fl);
        case (which)
            0: begin
                bsy = bus1.busy; dn = bus1.done; res = bus1.result;
                fl = {bus1.c_out, bus1.ovf, bus1.zero, bus1.neg};
            end
            1: begin
                bsy = bus8.busy; dn = bus8.done; res = bus8.result;
                fl = {bus8.c_out, bus8.ovf, bus8.zero, bus8.neg};
            end
            default: begin
                bsy = bus32.busy; dn = bus32.done; res = bus32.result;
                fl = {bus32.c_out, bus32.ovf, bus32.zero, bus32.neg};
            end
        endcase
    endtask

    // Launches one op, then scrambles the inputs while it runs; pokeAt > 0 re-asserts start
    // at that run cycle. Returns at the negedge where done is seen (or after a bound).
    task automatic doOp(input int which, input logic [1:0] op, input logic cin,
                        input logic [31:0] a, input logic [31:0] b, input int pokeAt,
                        output logic [31:0] res, output logic [3:0] fl,
                        output logic bsy, output int lat);
        logic dn;
        drive(which, 1'b1, op, cin, a, b);
        @(posedge clk);
        @(negedge clk);
        drive(which, 1'b0, ~op, ~cin, ~a, b ^ 32'hA5A5_A5A5);
        lat = 0;
        sample(which, bsy, dn, res, fl);
        while (!dn && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            drive(which, (lat == pokeAt), ~op, ~cin, ~a, b ^ 32'hA5A5_A5A5);
            sample(which, bsy, dn, res, fl);
        end
        drive(which, 1'b0, ~op, ~cin, ~a, b ^ 32'hA5A5_A5A5);
    endtask

    initial begin
        logic [31:0] res;
        logic [3:0]  fl;
        logic        bsy;
        logic        dn;
        int          lat;
        int          latOf[3] = '{32, 4, 1};

        for (int w = 0; w < 3; w++) drive(w, 1'b0, OP_ADD, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        sample(1, bsy, dn, res, fl);
        check("reset_busy_done", {bsy, dn}, 2'b00);
        check("reset_result", res, 32'h0);
        check("reset_flags", fl, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);

        doOp(1, OP_SUB, 1'b0, 32'd5, 32'd3, -1, res, fl, bsy, lat);
        check("sub_5_3_result", res, 32'd2);
        check("sub_5_3_flags", fl, 4'b1000);
        check("sub_5_3_latency", lat, 4);
        check("sub_5_3_busy_at_done", bsy, 1'b0);
        @(negedge clk);
        sample(1, bsy, dn, res, fl);
        check("done_single_cycle", dn, 1'b0);

        doOp(1, OP_SUB, 1'b0, 32'd3, 32'd5, -1, res, fl, bsy, lat);
        check("sub_3_5_result", res, 32'hFFFF_FFFE);
        check("sub_3_5_flags", fl, 4'b0001);

        // Launched in the cycle the previous done is high (back-to-back).
        doOp(1, OP_ADD, 1'b0, 32'h7FFF_FFFF, 32'h1, -1, res, fl, bsy, lat);
        check("add_ovf_result", res, 32'h8000_0000);
        check("add_ovf_flags", fl, 4'b0101);
        check("add_ovf_latency", lat, 4);

        doOp(1, OP_SUB, 1'b0, 32'h8000_0000, 32'h1, -1, res, fl, bsy, lat);
        check("sub_ovf_result", res, 32'h7FFF_FFFF);
        check("sub_ovf_flags", fl, 4'b1100);

        doOp(1, OP_ADD, 1'b0, 32'hFFFF_FFFF, 32'h1, -1, res, fl, bsy, lat);
        check("add_wrap_result", res, 32'h0);
        check("add_wrap_flags", fl, 4'b1010);
        doOp(1, OP_ADC, fl[3], 32'h0, 32'h0, -1, res, fl, bsy, lat);
        check("adc_chain_result", res, 32'h1);
        check("adc_chain_flags", fl, 4'b0000);

        doOp(1, OP_ADD, 1'b0, 32'h00FF_FFFF, 32'h1, -1, res, fl, bsy, lat);
        check("slice_carry_result", res, 32'h0100_0000);
        check("slice_carry_flags", fl, 4'b0000);

        doOp(1, OP_SBC, 1'b0, 32'd10, 32'd3, -1, res, fl, bsy, lat);
        check("sbc_result", res, 32'd6);
        check("sbc_flags", fl, 4'b1000);

        doOp(1, OP_ADD, 1'b0, 32'h1234_5678, 32'h1111_1111, 1, res, fl, bsy, lat);
        check("start_while_busy_result", res, 32'h2345_6789);
        check("start_while_busy_latency", lat, 4);
        @(negedge clk);
        sample(1, bsy, dn, res, fl);
        check("start_while_busy_no_rerun", {bsy, dn}, 2'b00);

        // Abort mid-operation: two run edges, then asynchronous reset.
        drive(1, 1'b1, OP_ADD, 1'b0, 32'h0101_0101, 32'h0101_0101);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, OP_ADD, 1'b0, 32'h0101_0101, 32'h0101_0101);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 sample(1, bsy, dn, res, fl);
        check("abort_busy_done", {bsy, dn}, 2'b00);
        check("abort_result", res, 32'h0);
        check("abort_flags", fl, 4'b0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sample(1, bsy, dn, res, fl);
        check("abort_no_done", {bsy, dn}, 2'b00);
        doOp(1, OP_ADD, 1'b0, 32'h0101_0101, 32'h0101_0101, -1, res, fl, bsy, lat);
        check("after_abort_result", res, 32'h0202_0202);
        check("after_abort_latency", lat, 4);

        for (int w = 0; w < 3; w++) begin
            for (int v = 0; v < 4; v++) begin
                logic [1:0]  op;
                logic        cin;
                logic        c0;
                logic [31:0] a;
                logic [31:0] b;
                logic [31:0] bb;
                logic [32:0] sum;
                logic [3:0]  expFl;
                op  = 2'($urandom_range(0, 3));
                cin = 1'($urandom_range(0, 1));
                a   = $urandom;
                b   = $urandom;
                bb  = op[0] ? ~b : b;
                c0  = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : cin;
                sum = {1'b0, a} + {1'b0, bb} + {32'h0, c0};
                expFl = {sum[32], (a[31] == bb[31]) && (sum[31] != a[31]), sum[31:0] == 32'h0, sum[31]};
                doOp(w, op, cin, a, b, -1, res, fl, bsy, lat);
                check($sformatf("rand_w%0d_v%0d_result", w, v), res, sum[31:0]);
                check($sformatf("rand_w%0d_v%0d_flags", w, v), fl, expFl);
                check($sformatf("rand_w%0d_v%0d_latency", w, v), lat, latOf[w]);
            end
        end

        $display("%0d/%0d checks passed", passCount, total);
        $finish;
    end
endmodule
